seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Time-multiplexed driver for the board's 4-digit common-anode 7-segment display. It sits directly downstream of the traffic-light controller, taking its four parallel 7-bit digit patterns (Seg4..Seg1) and driving one shared segment bus plus four digit selects. The digits are scanned round-robin, with a blanking interval between digits to suppress ghosting and a 3-bit brightness control implemented as on-time within each slot.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; 1 kHz per digit at 50 MHz.
- BLANK_CYC, 400: dark cycles at the start of each slot. (SCAN_DIV − BLANK_CYC) must be a positive multiple of 8.
- CLK_50MHz  in  1  system clock; all logic on its rising edge.
- Res  in  1  synchronous, active-high reset.
- Seg1  in  7  rightmost digit pattern, active-high per segment (bit0=a … bit6=g).
- Seg2, Seg3, Seg4  in  7 each  next digits leftward, same encoding.
- Dig_En  in  4  per-digit enable; bit i gates digit i (digit 0 = Seg1).
- Bright  in  3  brightness, 0 (dimmest) … 7 (full).
- Seg_Out  out  7  shared segment bus, active-low.
- Dig_Sel  out  4  digit selects, active-low, one-hot-low when lit.
- Scan_Tick  out  1  one-cycle pulse on the last cycle of every slot.

## Operation
- Registers: slot counter c (0..SCAN_DIV−1), digit index d (0..3), latched pattern P (7 b), latched enable E, latched brightness B.
- W = (SCAN_DIV − BLANK_CYC)/8 is the sub-window length.
- State machine, evaluated per cycle on c:
  - BLANK, c < BLANK_CYC: Seg_Out = 7'h7F, Dig_Sel = 4'hF.
  - SHOW, c ≥ BLANK_CYC: sub = (c − BLANK_CYC)/W (0..7).
    - If E = 1 and sub ≤ B: Dig_Sel bit d = 0, others 1; Seg_Out = ~P.
    - Otherwise: same outputs as BLANK.
- Slot start, c = 0:
  - P ← Seg(d+1).
  - E ← Dig_En[d].
  - B ← Bright.
  - Inputs are ignored for the rest of the slot.
- Slot end, c = SCAN_DIV−1:
  - Scan_Tick = 1 for that cycle.
  - Next edge: c ← 0, d ← d+1, wrapping 3 → 0.
- A disabled digit (E = 0) still consumes its full slot, and Scan_Tick still pulses.
- All outputs are registered and glitch-free. Dig_Sel never has more than one bit low.
- Reset: any edge with Res = 1 forces:
  - c = 0, d = 0, BLANK.
  - Seg_Out = 7'h7F, Dig_Sel = 4'hF, Scan_Tick = 0.
  - Applies equally mid-slot; there is no partial completion.

## Timing
- Cycle numbering: cycle 0 is the first cycle after the edge at which Res is sampled 0. The stated output values hold during that cycle.
- Lit window of a slot: cycles BLANK_CYC … BLANK_CYC + (B+1)·W − 1.
  - B = 7 lights through SCAN_DIV−1.
  - The blank gap between consecutive lit digits is ≥ BLANK_CYC cycles.
- Input-to-display latency: a Seg/Dig_En/Bright change is visible at the next c = 0 for that digit, worst case 4·SCAN_DIV cycles.
- Full frame: 4·SCAN_DIV cycles. Scan_Tick period: SCAN_DIV cycles.
- The first slot after reset is always digit 0 (Dig_Sel = 4'b1110).

## Test plan
All scenarios use SCAN_DIV = 40, BLANK_CYC = 8 (W = 4).

- Reset: hold Res = 1 for 3 cycles with arbitrary inputs -> Seg_Out = 7'h7F, Dig_Sel = 4'hF, Scan_Tick = 0 throughout.
- Full scan: Bright = 7, Dig_En = 4'hF, Seg1 = 7'h3F, Seg2 = 7'h06, Seg3 = 7'h5B, Seg4 = 7'h4F ->
  - Cycles 0–7: dark.
  - Cycles 8–39: Dig_Sel = 4'b1110, Seg_Out = 7'h40; Scan_Tick at cycle 39.
  - Cycles 48–79: Dig_Sel = 4'b1101, Seg_Out = 7'h79.
  - Cycles 128–159: Dig_Sel = 4'b0111, Seg_Out = 7'h30.
  - Cycle 168: Dig_Sel = 4'b1110 again.
- Brightness: Bright = 0 -> per slot, lit only cycles 8–11. Bright = 3 -> lit cycles 8–23.
- Digit disable: Dig_En = 4'b1011 -> slot 2 (cycles 80–119) fully dark, Scan_Tick still high at cycle 119, digit 3 lights at cycle 128.
- Mid-slot input change: set Seg1 = 7'h06 at cycle 20 of the digit-0 slot -> Seg_Out stays 7'h40 through cycle 39. Next digit-0 slot (cycle 168+) shows 7'h79.
- Reset mid-slot: assert Res at cycle 25 of the digit-2 slot -> next cycle dark, Scan_Tick = 0. After release, cycle 8 shows Dig_Sel = 4'b1110.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Round-robin scan with a blanking lead-in per slot and 8-step on-time brightness.
module seg_scan_mux #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 400
) (
  input  logic       CLK_50MHz,
  input  logic       Res,
  input  logic [6:0] Seg1,
  input  logic [6:0] Seg2,
  input  logic [6:0] Seg3,
  input  logic [6:0] Seg4,
  input  logic [3:0] Dig_En,
  input  logic [2:0] Bright,
  output logic [6:0] Seg_Out,
  output logic [3:0] Dig_Sel,
  output logic       Scan_Tick
);

  localparam int unsigned W  = (SCAN_DIV - BLANK_CYC) / 8;
  localparam int unsigned CW = $clog2(SCAN_DIV);

  localparam logic [CW-1:0] CntMax = CW'(SCAN_DIV - 1);
  localparam logic [CW:0]   BlankW = (CW+1)'(BLANK_CYC);
  localparam logic [CW:0]   WinW   = (CW+1)'(W);

  typedef enum logic {StBlank, StShow} phase_e;

  // cnt_q/dig_q describe the cycle that begins at the next edge, so every
  // output can be registered and still line up with the slot position.
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [6:0]    pat_q, pat_d;
  logic          en_q, en_d;
  logic [2:0]    bri_q, bri_d;
  logic [6:0]    seg_d;
  logic [3:0]    sel_d;
  logic          tick_d;
  logic [CW:0]   lit_end;
  phase_e        phase;
  logic          lit;

  always_comb begin
    pat_d   = pat_q;
    en_d    = en_q;
    bri_d   = bri_q;
    seg_d   = 7'h7F;
    sel_d   = 4'hF;
    tick_d  = 1'b0;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    lit_end = '0;
    phase   = StBlank;
    lit     = 1'b0;

    if (cnt_q == '0) begin
      unique case (dig_q)
        2'd0: pat_d = Seg1;
        2'd1: pat_d = Seg2;
        2'd2: pat_d = Seg3;
        2'd3: pat_d = Seg4;
      endcase
      en_d  = Dig_En[dig_q];
      bri_d = Bright;
    end

    tick_d = (cnt_q == CntMax);
    cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    dig_d  = tick_d ? dig_q + 2'd1 : dig_q;

    phase   = ({1'b0, cnt_q} < BlankW) ? StBlank : StShow;
    // Lit while sub-window index <= brightness, i.e. before BLANK + (B+1)*W.
    lit_end = BlankW + ((CW+1)'(bri_d) + (CW+1)'(1)) * WinW;
    lit     = (phase == StShow) && en_d && ({1'b0, cnt_q} < lit_end);

    if (lit) begin
      seg_d = ~pat_d;
      sel_d = ~(4'b0001 << dig_q);
    end
  end

  always_ff @(posedge CLK_50MHz) begin
    if (Res) begin
      cnt_q     <= '0;
      dig_q     <= '0;
      pat_q     <= '0;
      en_q      <= 1'b0;
      bri_q     <= '0;
      Seg_Out   <= 7'h7F;
      Dig_Sel   <= 4'hF;
      Scan_Tick <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      pat_q     <= pat_d;
      en_q      <= en_d;
      bri_q     <= bri_d;
      Seg_Out   <= seg_d;
      Dig_Sel   <= sel_d;
      Scan_Tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: directed scenarios with literal expectations
// plus randomized stimulus checked every cycle against a slot/position model.
module tb_seg_scan_mux;

  localparam int SD = 40;
  localparam int BC = 8;
  localparam int WL = (SD - BC) / 8;

  logic       clk = 1'b0;
  logic       res;
  logic [6:0] seg1, seg2, seg3, seg4;
  logic [3:0] en;
  logic [2:0] bri;
  logic [6:0] seg_out;
  logic [3:0] dig_sel;
  logic       tick;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .CLK_50MHz (clk),
    .Res       (res),
    .Seg1      (seg1),
    .Seg2      (seg2),
    .Seg3      (seg3),
    .Seg4      (seg4),
    .Dig_En    (en),
    .Bright    (bri),
    .Seg_Out   (seg_out),
    .Dig_Sel   (dig_sel),
    .Scan_Tick (tick)
  );

  // Model: k counts cycles since reset release; slot = k / SD, position = k % SD.
  int         k = 0;
  bit         valid = 1'b0;
  logic [6:0] lat_pat = '0;
  bit         lat_en = 1'b0;
  int         lat_bri = 0;
  logic [6:0] exp_seg;
  logic [3:0] exp_sel;
  logic       exp_tick;

  always @(posedge clk) begin
    if (res) begin
      k        = 0;
      valid    = 1'b1;
      exp_seg  = 7'h7F;
      exp_sel  = 4'hF;
      exp_tick = 1'b0;
    end else if (valid) begin
      int pos;
      int digit;
      pos   = k % SD;
      digit = (k / SD) % 4;
      if (pos == 0) begin
        case (digit)
          0:       lat_pat = seg1;
          1:       lat_pat = seg2;
          2:       lat_pat = seg3;
          default: lat_pat = seg4;
        endcase
        lat_en  = en[digit];
        lat_bri = int'(bri);
      end
      exp_seg = 7'h7F;
      exp_sel = 4'hF;
      if (pos >= BC && lat_en && ((pos - BC) / WL) <= lat_bri) begin
        exp_seg        = ~lat_pat;
        exp_sel[digit] = 1'b0;
      end
      exp_tick = (pos == SD - 1);
      k++;
    end
    if (valid) begin
      #1;
      tests++;
      if (seg_out !== exp_seg || dig_sel !== exp_sel || tick !== exp_tick) begin
        fails++;
        $display("FAIL model cyc=%0d seg_out=%h exp %h dig_sel=%b exp %b tick=%b exp %b",
                 k - 1, seg_out, exp_seg, dig_sel, exp_sel, tick, exp_tick);
      end
    end
  end

  task automatic chk(input string name, input logic [6:0] s, input logic [3:0] d,
                     input logic t);
    tests++;
    if (seg_out !== s || dig_sel !== d || tick !== t) begin
      fails++;
      $display("FAIL %s cyc=%0d seg_out=%h exp %h dig_sel=%b exp %b tick=%b exp %b",
               name, k - 1, seg_out, s, dig_sel, d, tick, t);
    end
  endtask

  task automatic run_to(input int n);
    for (int i = 0; i < 2000 && (k - 1) != n; i++) @(negedge clk);
    if ((k - 1) != n) begin
      tests++;
      fails++;
      $display("FAIL run_to cyc=%0d exp %0d", k - 1, n);
    end
  endtask

  task automatic rand_inputs();
    seg1 = 7'($urandom);
    seg2 = 7'($urandom);
    seg3 = 7'($urandom);
    seg4 = 7'($urandom);
    en   = 4'($urandom);
    bri  = 3'($urandom);
  endtask

  task automatic reset_hold();
    res = 1'b1;
    rand_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset", 7'h7F, 4'hF, 1'b0);
    end
  endtask

  task automatic set_digits();
    seg1 = 7'h3F;
    seg2 = 7'h06;
    seg3 = 7'h5B;
    seg4 = 7'h4F;
  endtask

  initial begin
    res = 1'b1;
    rand_inputs();
    @(negedge clk);

    // Full scan at full brightness.
    reset_hold();
    set_digits();
    en  = 4'hF;
    bri = 3'd7;
    res = 1'b0;
    run_to(0);   chk("fs_c0",   7'h7F, 4'hF,    1'b0);
    run_to(7);   chk("fs_c7",   7'h7F, 4'hF,    1'b0);
    run_to(8);   chk("fs_c8",   7'h40, 4'b1110, 1'b0);
    run_to(39);  chk("fs_c39",  7'h40, 4'b1110, 1'b1);
    run_to(40);  chk("fs_c40",  7'h7F, 4'hF,    1'b0);
    run_to(48);  chk("fs_c48",  7'h79, 4'b1101, 1'b0);
    run_to(128); chk("fs_c128", 7'h30, 4'b0111, 1'b0);
    run_to(168); chk("fs_c168", 7'h40, 4'b1110, 1'b0);

    // Mid-slot pattern change is deferred to the next digit-0 slot.
    run_to(180);
    seg1 = 7'h06;
    run_to(199); chk("mid_c199", 7'h40, 4'b1110, 1'b1);
    run_to(328); chk("mid_c328", 7'h79, 4'b1110, 1'b0);

    // Reset in the middle of a digit-2 slot.
    run_to(425); chk("d2_c25", 7'h24, 4'b1011, 1'b0);
    res = 1'b1;
    @(negedge clk);
    chk("midres", 7'h7F, 4'hF, 1'b0);
    res = 1'b0;
    run_to(8); chk("post_res_c8", 7'h79, 4'b1110, 1'b0);

    // Minimum brightness with digit 2 disabled.
    reset_hold();
    set_digits();
    en  = 4'b1011;
    bri = 3'd0;
    res = 1'b0;
    run_to(11);  chk("b0_c11",  7'h40, 4'b1110, 1'b0);
    run_to(12);  chk("b0_c12",  7'h7F, 4'hF,    1'b0);
    run_to(51);  chk("b0_c51",  7'h79, 4'b1101, 1'b0);
    run_to(52);  chk("b0_c52",  7'h7F, 4'hF,    1'b0);
    run_to(88);  chk("dis_c88", 7'h7F, 4'hF,    1'b0);
    run_to(119); chk("dis_c119", 7'h7F, 4'hF,   1'b1);
    run_to(128); chk("dis_c128", 7'h30, 4'b0111, 1'b0);
    run_to(132); chk("b0_c132", 7'h7F, 4'hF,    1'b0);

    // Brightness 3.
    reset_hold();
    set_digits();
    en  = 4'hF;
    bri = 3'd3;
    res = 1'b0;
    run_to(23); chk("b3_c23", 7'h40, 4'b1110, 1'b0);
    run_to(24); chk("b3_c24", 7'h7F, 4'hF,    1'b0);

    // Randomized stimulus, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) rand_inputs();
      res = ($urandom_range(0, 299) == 0);
    end
    res = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
